serial_pattern_gen: RTL and testbench
=====================================

Name: serial_pattern_gen

Overview:
- Parallel-to-serial stimulus stage that sits directly upstream of the serial sequence detector and drives its X input, one bit per clk.
- Accepts WIDTH-bit words through a valid/ready load handshake and shifts them out MSB- or LSB-first.
- A one-deep holding register lets a second word queue while the current one shifts, so words stream back-to-back with no bubble.
- Optional idle gap after the stream drains; detector sees a steady IDLE_VAL between bursts.

Parameters:
- WIDTH, 18, bits per word (>=2).
- MSB_FIRST, 1, 1 = din[WIDTH-1] sent first; 0 = din[0] first.
- GAP_CYCLES, 0, idle cycles forced on X after the last queued word finishes (0 = none).
- IDLE_VAL, 0, level driven on X when not shifting.

Ports:
- clk  in  1  rising-edge clock; one serial bit per cycle.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  word valid; transfer occurs on a rising edge where load=1 and ready=1.
- din  in  WIDTH  parallel word.
- ready  out  1  registered; 1 when the holding register is empty.
- X  out  1  serial output to the detector; registered.
- busy  out  1  1 while a word bit is on X or a gap is in progress.
- done  out  1  one-cycle pulse during the last bit of each word.

Behaviour:
- Reset (async, immediate): X=IDLE_VAL, busy=0, ready=1, done=0, state=IDLE, bit_cnt=0, shift and hold registers cleared. Reset mid-word aborts the word and drops any queued word; there is no partial completion and no done pulse.
- Storage: one shift register (WIDTH) plus one hold register (WIDTH, with a full flag). ready = !hold_full, registered.
- Accept: on an edge with load&ready, din is captured into hold and hold_full is set. load with ready=0 is ignored; the held word is never overwritten.
- FSM states are IDLE, SHIFT, GAP.
- IDLE: X=IDLE_VAL, busy=0. If hold_full, move hold to the shift register, clear hold_full, enter SHIFT.
  - A word loaded at edge n reaches hold at edge n, moves to the shift register at edge n+1, and X carries bit 0 of the stream during the cycle after edge n+1.
  - Latency from the load edge to the first bit on X is 2 clocks.
- SHIFT: X = current bit, bit_cnt counts 0..WIDTH-1, busy=1. done=1 exactly while bit_cnt==WIDTH-1.
  - At that last-bit edge, if hold_full: reload the shift register from hold, clear hold_full, set bit_cnt=0 and stay in SHIFT. The next word's first bit follows immediately, with zero idle cycles.
  - Otherwise go to GAP if GAP_CYCLES>0, else to IDLE.
- GAP: X=IDLE_VAL, busy=1 for exactly GAP_CYCLES cycles, then IDLE. A word accepted during GAP waits in hold until IDLE.
- Simultaneous events: hold drains (SHIFT reload or IDLE pickup) on the same edge that load is sampled. Because ready is registered, that load is ignored; ready rises the following cycle.
- Bit order: MSB_FIRST=1 shifts left and takes the MSB; 0 shifts right and takes the LSB.
- Counter width: $clog2(WIDTH); wrap occurs only via the explicit reset to 0.
- All outputs are registered; no combinational path from load or din to X.

Decomposition:
- Shared package holds the state enum (IDLE/SHIFT/GAP) and the bit-counter width function.
- One natural sub-module: piso_shreg, a WIDTH-bit parallel-load shift register with a MSB_FIRST parameter and a serial output.
- FSM, hold register and handshake stay in serial_pattern_gen.

Test Plan:
- Reset check: assert rst for 3 cycles, then release -> X=0, busy=0, ready=1, done=0; deassert during a word, then check that X returns to 0 immediately and no done pulse follows.
- Basic MSB-first: WIDTH=18, load din=18'b110001110100111100 at edge n -> X from cycle n+2 reads 1,1,0,0,0,1,1,1,0,1,0,0,1,1,1,1,0,0; done is high only on the 18th bit; then IDLE with X=0.
- LSB-first: MSB_FIRST=0, WIDTH=4, din=4'b0001 -> X sequence 1,0,0,0.
- Back-to-back: load A=18'h3FFFF, then load B=18'h00000 as soon as ready returns -> 18 ones immediately followed by 18 zeros, two done pulses 18 cycles apart, and busy never drops.
- Backpressure: with hold full, pulse load with din=18'h15555 -> ignored; the queued word is output unchanged and ready stays 0 until the reload edge.
- Gap: GAP_CYCLES=3, a single word -> after the last bit X=IDLE_VAL with busy=1 for exactly 3 cycles, then busy=0; a word loaded during the gap starts only after IDLE.

Source files
------------

// File: rtl/serial_pattern_gen_pkg.sv
// Shared types and helpers for the serial pattern generator.
package serial_pattern_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load shift register with selectable bit order and a look-ahead serial output.
module piso_shreg #(
  parameter int unsigned WIDTH     = 18,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_sout_nxt
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;

  // Next contents: parallel load wins over shift.
  always_comb begin
    w_data_nxt = r_data;
    if (i_load) begin
      w_data_nxt = i_din;
    end else if (i_shift) begin
      if (MSB_FIRST) w_data_nxt = {r_data[WIDTH-2:0], 1'b0};
      else           w_data_nxt = {1'b0, r_data[WIDTH-1:1]};
    end
  end

  // Shift register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_data <= '0;
    else     r_data <= w_data_nxt;
  end

  // Bit that will be on the serial line after this edge; lets the parent register X directly.
  assign o_sout_nxt = MSB_FIRST ? w_data_nxt[WIDTH-1] : w_data_nxt[0];

endmodule

// File: rtl/serial_pattern_gen.sv
// Parallel-to-serial stimulus generator: valid/ready word load, one-deep hold, optional idle gap.
module serial_pattern_gen
  import serial_pattern_gen_pkg::*;
#(
  parameter int unsigned WIDTH      = 18,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          IDLE_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             X,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW    = cnt_width(WIDTH);
  localparam int unsigned GapW    = cnt_width(GAP_CYCLES);
  localparam int unsigned GapLstI = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GapLstI);

  state_e            r_state, w_state_nxt;
  logic [CntW-1:0]   r_cnt, w_cnt_nxt;
  logic [GapW-1:0]   r_gap, w_gap_nxt;
  logic [WIDTH-1:0]  r_hold;
  logic              r_hold_full, w_hold_full_nxt;
  logic              r_ready, r_x, r_busy, r_done;
  logic              w_accept, w_sh_load, w_sh_shift, w_sout_nxt;

  // ready is registered, so a load on the draining edge is ignored by construction.
  assign w_accept = load & r_ready;

  piso_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_piso_shreg (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_sh_load),
    .i_shift   (w_sh_shift),
    .i_din     (r_hold),
    .o_sout_nxt(w_sout_nxt)
  );

  // Next-state, counters and shift-register control.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_sh_load   = 1'b0;
    w_sh_shift  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_hold_full) begin
          w_sh_load   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = StShift;
        end
      end
      StShift: begin
        if (r_cnt == LastCnt) begin
          w_cnt_nxt = '0;
          if (r_hold_full) begin
            // Queued word follows with no bubble.
            w_sh_load = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            w_gap_nxt   = '0;
            w_state_nxt = StGap;
          end else begin
            w_state_nxt = StIdle;
          end
        end else begin
          w_sh_shift = 1'b1;
          w_cnt_nxt  = r_cnt + CntW'(1);
        end
      end
      StGap: begin
        if (r_gap == GapLast) w_state_nxt = StIdle;
        else                  w_gap_nxt   = r_gap + GapW'(1);
      end
      default: w_state_nxt = StIdle;
    endcase
    w_hold_full_nxt = (r_hold_full & ~w_sh_load) | w_accept;
  end

  // State, counters, hold register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
      r_x         <= IDLE_VAL;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gap       <= w_gap_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_ready     <= ~w_hold_full_nxt;
      r_x         <= (w_state_nxt == StShift) ? w_sout_nxt : IDLE_VAL;
      r_busy      <= (w_state_nxt != StIdle);
      r_done      <= (w_state_nxt == StShift) && (w_cnt_nxt == LastCnt);
      if (w_accept) r_hold <= din;
    end
  end

  assign ready = r_ready;
  assign X     = r_x;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: default, LSB-first and gap configurations.
module tb_serial_pattern_gen;

  logic        clk;
  logic        rst;
  logic        load,   ready,   x,   busy,   done;
  logic [17:0] din;
  logic        l_load, l_ready, l_x, l_busy, l_done;
  logic [3:0]  l_din;
  logic        g_load, g_ready, g_x, g_busy, g_done;
  logic [17:0] g_din;

  int n_vec;
  int n_err;

  serial_pattern_gen #(
    .WIDTH(18), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_VAL(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst), .load(load), .din(din),
    .ready(ready), .X(x), .busy(busy), .done(done)
  );

  serial_pattern_gen #(
    .WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_VAL(1'b0)
  ) u_lsb (
    .clk(clk), .rst(rst), .load(l_load), .din(l_din),
    .ready(l_ready), .X(l_x), .busy(l_busy), .done(l_done)
  );

  serial_pattern_gen #(
    .WIDTH(18), .MSB_FIRST(1'b1), .GAP_CYCLES(3), .IDLE_VAL(1'b0)
  ) u_gap (
    .clk(clk), .rst(rst), .load(g_load), .din(g_din),
    .ready(g_ready), .X(g_x), .busy(g_busy), .done(g_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Two words on the main DUT: A, then B as soon as ready returns.
  // With hold_c set, load stays asserted with c while the hold is full; it must be ignored.
  task automatic run_pair(input logic [17:0] a, input logic [17:0] b, input logic [17:0] c,
                          input bit hold_c);
    logic [35:0] s;
    s = {a, b};
    load = 1'b1;
    din  = a;
    tick();
    load = 1'b0;
    chk("pair_ready_after_load", ready, 1'b0);
    for (int i = 0; i < 36; i++) begin
      tick();
      chk("pair_x", x, s[35-i]);
      chk("pair_busy", busy, 1'b1);
      chk("pair_done", done, (i == 17) || (i == 35));
      chk("pair_ready", ready, (i == 0) || (i >= 18));
      if (i == 0) begin
        load = 1'b1;
        din  = b;
      end else if (i == 1) begin
        load = hold_c;
        din  = c;
      end else if (i == 18) begin
        load = 1'b0;
      end
    end
    tick();
    chk("pair_idle_x", x, 1'b0);
    chk("pair_idle_busy", busy, 1'b0);
    chk("pair_idle_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pair_no_extra_word", busy, 1'b0);
    end
  endtask

  initial begin
    logic [17:0] pat;
    logic [3:0]  lpat;
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    load   = 1'b0;
    din    = '0;
    l_load = 1'b0;
    l_din  = '0;
    g_load = 1'b0;
    g_din  = '0;

    // Reset held for three cycles.
    repeat (3) tick();
    chk("rst_x", x, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_x", x, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_ready", ready, 1'b1);

    // Basic MSB-first word; first bit appears two clocks after the load edge.
    pat  = 18'b110001110100111100;
    load = 1'b1;
    din  = pat;
    tick();
    load = 1'b0;
    chk("basic_x_latency", x, 1'b0);
    chk("basic_busy_latency", busy, 1'b0);
    chk("basic_ready_low", ready, 1'b0);
    for (int i = 0; i < 18; i++) begin
      tick();
      chk("basic_x", x, pat[17-i]);
      chk("basic_done", done, i == 17);
      chk("basic_busy", busy, 1'b1);
    end
    tick();
    chk("basic_idle_x", x, 1'b0);
    chk("basic_idle_busy", busy, 1'b0);
    chk("basic_idle_done", done, 1'b0);

    // Back-to-back streaming, then backpressure with a rejected word.
    run_pair(18'h3FFFF, 18'h00000, 18'h00000, 1'b0);
    run_pair(18'h0F0F3, 18'h30C3A, 18'h15555, 1'b1);

    // LSB-first, WIDTH=4.
    lpat   = 4'b0001;
    l_load = 1'b1;
    l_din  = lpat;
    tick();
    l_load = 1'b0;
    chk("lsb_latency", l_x, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lsb_x", l_x, lpat[i]);
      chk("lsb_done", l_done, i == 3);
    end
    tick();
    chk("lsb_idle_busy", l_busy, 1'b0);

    // Three-cycle gap; a word loaded during the gap waits for IDLE.
    pat    = 18'h20001;
    g_load = 1'b1;
    g_din  = pat;
    tick();
    g_load = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tick();
      chk("gap_word_x", g_x, pat[17-i]);
      chk("gap_word_done", g_done, i == 17);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_x", g_x, 1'b0);
      chk("gap_busy", g_busy, 1'b1);
      chk("gap_done", g_done, 1'b0);
      if (i == 0) begin
        g_load = 1'b1;
        g_din  = 18'h3FFFF;
      end else if (i == 1) begin
        g_load = 1'b0;
        chk("gap_hold_ready", g_ready, 1'b0);
      end
    end
    tick();
    chk("gap_end_busy", g_busy, 1'b0);
    chk("gap_end_x", g_x, 1'b0);
    tick();
    chk("gap_queued_start_x", g_x, 1'b1);
    chk("gap_queued_start_busy", g_busy, 1'b1);

    // Reset mid-word with a second word queued: both dropped, no done pulse.
    load = 1'b1;
    din  = 18'h3FFFF;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1;
    din  = 18'h2AAAA;
    tick();
    load = 1'b0;
    repeat (3) tick();
    chk("midrst_pre_x", x, 1'b1);
    chk("midrst_pre_ready", ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_x", x, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_done", done, 1'b0);
    chk("midrst_gap_busy", g_busy, 1'b0);
    tick();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("midrst_after_x", x, 1'b0);
      chk("midrst_after_busy", busy, 1'b0);
      chk("midrst_after_done", done, 1'b0);
    end
    chk("midrst_after_ready", ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
